hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It sits beside the decode stage and consumes the decoded register fields and 8-bit control word of the instruction in ID. It tracks the EX/MEM/WB occupancy internally, and from that produces stall, bubble, flush and forwarding-select signals. It also freezes the pipeline while data memory is busy and flags a sticky timeout if memory never answers.

## Interface
- `MEM_TIMEOUT`, 16: consecutive freeze cycles after which `mem_timeout` sets.
- `CNT_W`, 16: width of the saturating stall-cycle counter.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5: source registers of the ID instruction.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction reads that source.
- `id_rd` in 5: destination register of the ID instruction.
- `id_cs` in 8: control word, bits [7:0] = reg_write, alu_src, writeback, mem_read, mem_write, branch, jump, jalr.
- `ex_branch_taken` in 1: the branch in EX resolved taken this cycle.
- `mem_busy` in 1: data memory has not completed the access of the MEM-stage instruction.
- `stall_if`, `stall_id` out 1: hold the PC / hold the IF/ID register.
- `bubble_ex` out 1: load a NOP into ID/EX instead of the ID instruction.
- `flush_if` out 1: squash the IF/ID register (it loads a NOP).
- `freeze` out 1: hold every pipeline register.
- `fwd_a`, `fwd_b` out 2: EX operand source. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- `ex_valid`, `mem_valid`, `wb_valid` out 1: stage occupancy.
- `mem_timeout` out 1: sticky error flag.
- `stall_cnt` out CNT_W: saturating count of cycles with `stall_id`, `bubble_ex` or `freeze` asserted.

## Operation
- **Slot registers.** Three slot registers: EX, MEM and WB.
  - Each slot holds: valid, rd, reg_write, mem_read, mem_write.
  - The EX slot additionally holds rs1/rs2 and the use flags.
- **Advance.** On each edge with `freeze`=0:
  - WB takes MEM, and MEM takes EX.
  - EX takes the ID instruction if `id_valid`=1 and `bubble_ex`=0; otherwise EX takes an invalid slot.
  - When `freeze`=1, all slots hold.
- **Freeze.** `freeze` = `mem_valid` & (mem_read | mem_write of the MEM slot) & `mem_busy`.
- **Load-use.** `lu` = EX valid & EX mem_read & EX rd≠0 & `id_valid` & ((`id_uses_rs1` & `id_rs1`==EX rd) | (`id_uses_rs2` & `id_rs2`==EX rd)).
- **Output priority** (first match wins):
  1. `freeze`: `stall_if`=`stall_id`=1, `bubble_ex`=0, `flush_if`=0. `ex_branch_taken` is ignored; it is acted on in the first unfrozen cycle.
  2. `ex_branch_taken`: `flush_if`=1, `bubble_ex`=1, no stall. Two wrong-path slots are lost.
  3. `lu`: `stall_if`=`stall_id`=1, `bubble_ex`=1.
  4. `id_valid` & (`id_cs[1]` | `id_cs[0]`): `flush_if`=1. The jump advances into EX, and the IF slot fetched behind it is lost.
  5. Otherwise all four outputs are 0.
- **Forwarding.** Computed from the EX slot's rs1 (and separately rs2), for a used source with rs≠0:
  - Select 01 if MEM is valid, has reg_write and not mem_read, and MEM rd == rs.
  - Else select 10 if WB is valid, has reg_write and WB rd == rs.
  - Else select 00.
  - MEM takes priority over WB.
- **x0 rule.** rd=0 never creates a hazard or a forward.
- **Timeout counter.** A wait counter increments on every freeze cycle and clears on any non-freeze cycle.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout` sets.
  - `mem_timeout` clears only on reset. The pipeline stays frozen while `mem_busy` remains high.
- **Stall counter.** `stall_cnt` increments on the qualifying cycles and saturates at all-ones.

## Timing
- **Reset.** While `rst_n`=0, all slots are invalid, both counters and `mem_timeout` are 0, and every output is 0, combinational ones included. The first edge after release advances normally.
- **Combinational outputs.** `stall_*`, `bubble_ex`, `flush_if`, `freeze` and `fwd_*` are combinational, with zero latency from inputs and slot state.
- **Load-use sequence:**
  - Cycle N: one stall.
  - N+1: the load is in MEM and no hazard remains.
  - N+2: the consumer is in EX with `fwd`=10.
- **Simultaneous events:**
  - A branch taken in the same cycle as `lu`: the branch wins, and the ID instruction is discarded.
  - A jump in ID with `lu`: stall first; `flush_if` asserts in the cycle the jump actually advances.
- **Freeze release.** `mem_busy` falling ends the freeze on that cycle. The MEM instruction advances on the next edge.
- **Async reset during freeze** aborts everything immediately.

## Test plan
- **Back-to-back ALU dependency.** Stimulus: `add x5,…` then `add x6,x5,x5`. Response: the consumer in EX sees `fwd_a`=`fwd_b`=01, with no stall.
- **Load-use.** Stimulus: `lw x7` in EX, with `id_rs1`=7, `id_uses_rs1`=1 in ID. Response:
  - One cycle of `stall_if`=`stall_id`=`bubble_ex`=1, and `stall_cnt` 0→1.
  - Then `fwd_a`=10 when the consumer is in EX.
- **x0 destination.** Stimulus: the load targets rd=0 with a matching source. Response: no stall, `fwd`=00.
- **Branch vs load-use.** Stimulus: `ex_branch_taken`=1 together with a load-use condition. Response: `flush_if`=1, `bubble_ex`=1, `stall_id`=0.
- **Jump.** Stimulus: JALR in ID (`id_cs`=8'b11000011). Response: `flush_if`=1 for exactly one cycle.
- **Memory busy and timeout.** Stimulus: `sw` in MEM, `mem_busy` held for 20 cycles. Response:
  - `freeze`=1 throughout, and the slots are unchanged.
  - `mem_timeout` sets on the 16th freeze cycle and stays 1 after `mem_busy` drops.
  - Asserting `rst_n`=0 mid-freeze zeroes all outputs immediately.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard controller bundle: decoded ID fields, branch/memory status in; stall, flush, forward,
// occupancy and error status out.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic [7:0]       id_cs;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_if;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_cs,
    output ex_branch_taken, mem_busy,
    input  stall_if, stall_id, bubble_ex, flush_if, freeze, fwd_a, fwd_b,
    input  ex_valid, mem_valid, wb_valid, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_cs,
    input  ex_branch_taken, mem_busy,
    output stall_if, stall_id, bubble_ex, flush_if, freeze, fwd_a, fwd_b,
    output ex_valid, mem_valid, wb_valid, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: shadows EX/MEM/WB occupancy and derives stall,
// bubble, flush, freeze and forwarding selects, plus a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz_io
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q, wb_q;
  logic [4:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic             ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       freeze, lu, jump;
  logic       stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input slot_t mem_s, input slot_t wb_s);
    logic [1:0] sel;
    sel = 2'b00;
    // rs == 0 excludes x0, so a slot with rd == 0 can never match
    if (use_rs && (rs != 5'd0)) begin
      if (mem_s.valid && mem_s.reg_write && !mem_s.mem_read && (mem_s.rd == rs)) begin
        sel = 2'b01;
      end else if (wb_s.valid && wb_s.reg_write && (wb_s.rd == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    freeze = mem_q.valid & (mem_q.mem_read | mem_q.mem_write) & hz_io.mem_busy;
    lu     = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & hz_io.id_valid &
             ((hz_io.id_uses_rs1 & (hz_io.id_rs1 == ex_q.rd)) |
              (hz_io.id_uses_rs2 & (hz_io.id_rs2 == ex_q.rd)));
    jump   = hz_io.id_valid & (hz_io.id_cs[1] | hz_io.id_cs[0]);

    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    // Reset gate keeps input-driven outputs quiet while rst_n is low
    if (!rst_n) begin
      stall = 1'b0;
    end else if (freeze) begin
      stall = 1'b1;
    end else if (hz_io.ex_branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (lu) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else if (jump) begin
      flush = 1'b1;
    end

    fwd_a = ex_q.valid ? fwd_sel(ex_rs1_q, ex_use1_q, mem_q, wb_q) : 2'b00;
    fwd_b = ex_q.valid ? fwd_sel(ex_rs2_q, ex_use2_q, mem_q, wb_q) : 2'b00;
  end

  always_comb begin
    ex_d      = '0;
    ex_rs1_d  = 5'd0;
    ex_rs2_d  = 5'd0;
    ex_use1_d = 1'b0;
    ex_use2_d = 1'b0;
    if (hz_io.id_valid && !bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = hz_io.id_rd;
      ex_d.reg_write = hz_io.id_cs[7];
      ex_d.mem_read  = hz_io.id_cs[4];
      ex_d.mem_write = hz_io.id_cs[3];
      ex_rs1_d       = hz_io.id_rs1;
      ex_rs2_d       = hz_io.id_rs2;
      ex_use1_d      = hz_io.id_uses_rs1;
      ex_use2_d      = hz_io.id_uses_rs2;
    end

    // Wait counter saturates at the threshold so it cannot wrap during a long hang
    if (!freeze) begin
      wait_d = '0;
    end else if (wait_q == WaitW'(MEM_TIMEOUT)) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 1'b1;
    end
    timeout_d = timeout_q | (wait_d == WaitW'(MEM_TIMEOUT));

    stall_cnt_d = stall_cnt_q;
    if ((stall | bubble | freeze) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (!freeze) begin
        wb_q      <= mem_q;
        mem_q     <= ex_q;
        ex_q      <= ex_d;
        ex_rs1_q  <= ex_rs1_d;
        ex_rs2_q  <= ex_rs2_d;
        ex_use1_q <= ex_use1_d;
        ex_use2_q <= ex_use2_d;
      end
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz_io.stall_if    = stall;
  assign hz_io.stall_id    = stall;
  assign hz_io.bubble_ex   = bubble;
  assign hz_io.flush_if    = flush;
  assign hz_io.freeze      = freeze;
  assign hz_io.fwd_a       = fwd_a;
  assign hz_io.fwd_b       = fwd_b;
  assign hz_io.ex_valid    = ex_q.valid;
  assign hz_io.mem_valid   = mem_q.valid;
  assign hz_io.wb_valid    = wb_q.valid;
  assign hz_io.mem_timeout = timeout_q;
  assign hz_io.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked against a
// stage-list reference model.
module tb_hazard_ctrl;

  localparam int unsigned MemTimeout = 16;
  localparam int unsigned CntW       = 16;

  localparam logic [7:0] CsAlu   = 8'b10100000;
  localparam logic [7:0] CsLoad  = 8'b11110000;
  localparam logic [7:0] CsStore = 8'b01001000;
  localparam logic [7:0] CsJalr  = 8'b11000011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CntW)) hz();

  hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz_io(hz.slave)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit u1, u2, rw, mr, mw;
  } ins_t;

  ins_t pipe[3];
  int   m_wait, m_cnt;
  bit   m_to;
  bit   e_frz, e_stall, e_bub, e_flush;
  int   e_fa, e_fb;

  function automatic int exp_fwd(int rs, bit u);
    if (!pipe[0].v || !u || rs == 0) return 0;
    if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].rd == rs) return 1;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
    m_wait = 0;
    m_cnt  = 0;
    m_to   = 0;
  endtask

  task automatic model_eval();
    bit lu, jmp, hit1, hit2;
    e_frz = pipe[1].v && (pipe[1].mr || pipe[1].mw) && hz.mem_busy;
    hit1  = hz.id_uses_rs1 && (int'(hz.id_rs1) == pipe[0].rd);
    hit2  = hz.id_uses_rs2 && (int'(hz.id_rs2) == pipe[0].rd);
    lu    = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && hz.id_valid && (hit1 || hit2);
    jmp   = hz.id_valid && (hz.id_cs[1] || hz.id_cs[0]);
    e_stall = 0; e_bub = 0; e_flush = 0;
    if (e_frz) e_stall = 1;
    else if (hz.ex_branch_taken) begin e_flush = 1; e_bub = 1; end
    else if (lu) begin e_stall = 1; e_bub = 1; end
    else if (jmp) e_flush = 1;
    e_fa = exp_fwd(pipe[0].rs1, pipe[0].u1);
    e_fb = exp_fwd(pipe[0].rs2, pipe[0].u2);
  endtask

  task automatic model_commit();
    if (!e_frz) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{default: 0};
      if (hz.id_valid && !e_bub) begin
        pipe[0].v  = 1;
        pipe[0].rd = hz.id_rd;   pipe[0].rs1 = hz.id_rs1;  pipe[0].rs2 = hz.id_rs2;
        pipe[0].u1 = hz.id_uses_rs1; pipe[0].u2 = hz.id_uses_rs2;
        pipe[0].rw = hz.id_cs[7]; pipe[0].mr = hz.id_cs[4]; pipe[0].mw = hz.id_cs[3];
      end
    end
    m_wait = e_frz ? m_wait + 1 : 0;
    if (m_wait >= MemTimeout) m_to = 1;
    if ((e_stall || e_bub || e_frz) && m_cnt < (2 ** CntW) - 1) m_cnt++;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [7:0] cs);
    hz.id_valid = v;   hz.id_rd = rd;
    hz.id_rs1 = rs1;   hz.id_uses_rs1 = u1;
    hz.id_rs2 = rs2;   hz.id_uses_rs2 = u2;
    hz.id_cs = cs;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'd0);
    hz.ex_branch_taken = 1'b0;
    hz.mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, CsJalr);
    hz.ex_branch_taken = 1'b1;
    hz.mem_busy = 1'b1;
    #1;
    obs = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.freeze, hz.fwd_a, hz.fwd_b,
           hz.ex_valid, hz.mem_valid, hz.wb_valid, hz.mem_timeout};
    checks++;
    if (obs !== 13'd0) $display("FAIL reset_outputs: got %b want 0", obs);
    else passed++;
    checks++;
    if (hz.stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", hz.stall_cnt);
    else passed++;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    #1;
    obs = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.freeze, hz.fwd_a, hz.fwd_b,
           hz.ex_valid, hz.mem_valid, hz.wb_valid, hz.mem_timeout};
    checks++;
    if (obs !== 13'd0) $display("FAIL reset_release: got %b want 0", obs);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, CsAlu);
    tick();
    set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd5, 1'b1, CsAlu);
    #1;
    checks++;
    if ({hz.stall_id, hz.bubble_ex} !== 2'b00)
      $display("FAIL b2b_no_stall: got %b want 00", {hz.stall_id, hz.bubble_ex});
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b0101)
      $display("FAIL b2b_fwd: got %b want 0101", {hz.fwd_a, hz.fwd_b});
    else passed++;
    checks++;
    if (hz.stall_cnt !== '0) $display("FAIL b2b_stall_cnt: got %0d want 0", hz.stall_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 5'd0, 1'b0, CsLoad);
    tick();
    set_id(1'b1, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0, CsAlu);
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if} !== 4'b1110)
      $display("FAIL lu_stall: got %b want 1110",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if});
    else passed++;
    tick();
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if} !== 4'b0000)
      $display("FAIL lu_release: got %b want 0000",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if});
    else passed++;
    checks++;
    if (hz.stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d want 1", hz.stall_cnt);
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if ({hz.fwd_a, hz.ex_valid, hz.mem_valid, hz.wb_valid} !== 5'b10101)
      $display("FAIL lu_fwd_wb: got %b want 10101",
               {hz.fwd_a, hz.ex_valid, hz.mem_valid, hz.wb_valid});
    else passed++;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, CsLoad);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 5'd0, 1'b1, CsAlu);
    #1;
    checks++;
    if ({hz.stall_id, hz.bubble_ex} !== 2'b00)
      $display("FAIL x0_no_stall: got %b want 00", {hz.stall_id, hz.bubble_ex});
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b, hz.ex_valid} !== 5'b00001)
      $display("FAIL x0_no_fwd: got %b want 00001", {hz.fwd_a, hz.fwd_b, hz.ex_valid});
    else passed++;
    tick();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 5'd0, 1'b0, CsLoad);
    tick();
    set_id(1'b1, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0, CsAlu);
    hz.ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if} !== 4'b0011)
      $display("FAIL br_vs_lu: got %b want 0011",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if});
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if ({hz.ex_valid, hz.mem_valid, hz.stall_cnt} !== {2'b01, 16'd1})
      $display("FAIL br_discard: got ex=%b mem=%b cnt=%0d want ex=0 mem=1 cnt=1",
               hz.ex_valid, hz.mem_valid, hz.stall_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_jump();
    int flushes;
    do_reset();
    set_id(1'b1, 5'd1, 5'd3, 1'b1, 5'd0, 1'b0, CsJalr);
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if} !== 4'b0001)
      $display("FAIL jump_flush: got %b want 0001",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if});
    else passed++;
    tick();
    idle();
    #1;
    checks++;
    if ({hz.flush_if, hz.ex_valid} !== 2'b01)
      $display("FAIL jump_one_cycle: got %b want 01", {hz.flush_if, hz.ex_valid});
    else passed++;
    tick();
    // Jump stuck behind a load-use: flush only when it really advances
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 5'd0, 1'b0, CsLoad);
    tick();
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 5'd0, 1'b0, CsJalr);
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if} !== 4'b1110)
      $display("FAIL jump_lu_stall: got %b want 1110",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if});
    else passed++;
    flushes = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) idle();
      #1;
      if (hz.flush_if === 1'b1) flushes++;
    end
    checks++;
    if (flushes != 1) $display("FAIL jump_lu_flush_count: got %0d want 1", flushes);
    else passed++;
  endtask

  task automatic test_mem_timeout();
    logic [9:0] obs;
    logic [12:0] all;
    do_reset();
    set_id(1'b1, 5'd3, 5'd1, 1'b1, 5'd0, 1'b0, CsAlu);
    tick();
    set_id(1'b1, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, CsStore);
    tick();
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 5'd0, 1'b0, CsAlu);
    tick();
    idle();
    hz.mem_busy = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      hz.ex_branch_taken = (k == 5);
      #1;
      obs = {hz.freeze, hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if,
             hz.ex_valid, hz.mem_valid, hz.wb_valid, hz.fwd_a};
      checks++;
      if (obs !== 10'b11100_111_10)
        $display("FAIL freeze_hold k=%0d: got %b want 1110011110", k, obs);
      else passed++;
      checks++;
      if (hz.mem_timeout !== (k >= 17))
        $display("FAIL timeout_set k=%0d: got %b want %b", k, hz.mem_timeout, (k >= 17));
      else passed++;
      tick();
    end
    hz.ex_branch_taken = 1'b0;
    hz.mem_busy = 1'b0;
    #1;
    checks++;
    if ({hz.freeze, hz.mem_timeout, hz.stall_cnt} !== {2'b01, 16'd20})
      $display("FAIL freeze_release: got frz=%b to=%b cnt=%0d want frz=0 to=1 cnt=20",
               hz.freeze, hz.mem_timeout, hz.stall_cnt);
    else passed++;
    tick();
    checks++;
    if ({hz.mem_timeout, hz.ex_valid, hz.mem_valid, hz.wb_valid} !== 4'b1011)
      $display("FAIL timeout_sticky: got %b want 1011",
               {hz.mem_timeout, hz.ex_valid, hz.mem_valid, hz.wb_valid});
    else passed++;
    // Second freeze, aborted by reset in mid-cycle
    set_id(1'b1, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, CsStore);
    tick();
    idle();
    tick();
    hz.mem_busy = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    hz.ex_branch_taken = 1'b1;
    #1;
    all = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.freeze, hz.fwd_a, hz.fwd_b,
           hz.ex_valid, hz.mem_valid, hz.wb_valid, hz.mem_timeout};
    checks++;
    if ({all, hz.stall_cnt} !== 29'd0)
      $display("FAIL reset_mid_freeze: got %b cnt=%0d want all 0", all, hz.stall_cnt);
    else passed++;
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [12:0] obs, ev;
    logic [7:0]  cs;
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      cs = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cs[1:0] = 2'b00;
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), cs);
      hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
      hz.mem_busy = (i >= 200 && i < 225) ? 1'b1 : ($urandom_range(0, 3) == 0);
      #1;
      model_eval();
      obs = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.freeze, hz.fwd_a, hz.fwd_b,
             hz.ex_valid, hz.mem_valid, hz.wb_valid, hz.mem_timeout};
      ev  = {e_stall, e_stall, e_bub, e_flush, e_frz, 2'(e_fa), 2'(e_fb),
             pipe[0].v, pipe[1].v, pipe[2].v, m_to};
      checks++;
      if (obs !== ev) $display("FAIL rand_ctrl cycle %0d: got %b want %b", i, obs, ev);
      else passed++;
      checks++;
      if (hz.stall_cnt !== CntW'(m_cnt))
        $display("FAIL rand_stall_cnt cycle %0d: got %0d want %0d", i, hz.stall_cnt, m_cnt);
      else passed++;
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_branch_vs_lu();
    test_jump();
    test_mem_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
